pwm_bank: RTL and testbench
===========================

# pwm_bank

Eight-channel PWM generator that consumes the eight 16-bit duty words produced by the serial-input reader stage. Duty words are captured into shadow registers on the reader's one-cycle frame-complete strobe and are committed to the active compare registers only at a PWM period boundary, so outputs never glitch mid-period. The block sits directly downstream of the serial reader and drives the LED/FET pins.

## Interface
- TOP, 16'hFFFF: terminal count of the period counter; period = TOP+1 ticks.
- PRESCALE, 1: clock cycles per counter tick; legal range 1..65536.
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- frame_done  input  1  one-cycle strobe from the reader: all eight words are valid this cycle.
- v0..v7  input  16 each  duty words from the reader; sampled only when frame_done=1.
- pwm_out  output  8  registered PWM outputs; bit i is driven by duty word vi.
- period_start  output  1  one-cycle pulse on the first cycle of each period.
- pending  output  1  high while a captured frame awaits commit.

## Operation
- Prescaler: `pre` counts 0..PRESCALE-1 and wraps; tick = (pre == PRESCALE-1). With PRESCALE=1, tick is high every cycle.
- Period counter `count` (16 bits):
  - Advances only on tick.
  - When count == TOP at a tick, it wraps to 0; otherwise it increments.
  - `wrap` = tick && count == TOP.
- Capture: on frame_done, shadow[i] <= vi for all i and pending <= 1. Inputs are ignored at all other times, because the reader's values change bit-by-bit while shifting.
- Commit: on wrap with pending=1, active[i] <= shadow[i] and pending <= 0. On wrap with pending=0, active is unchanged.
- Simultaneous frame_done and wrap: the commit bypasses the shadow registers.
  - active[i] <= vi and shadow[i] <= vi.
  - pending <= 0.
- Back-to-back frames before a wrap: the last frame wins. Earlier frames are overwritten in shadow; no error is raised.
- Compare: pwm_out[i] <= (count < active[i]), unsigned 16-bit compare, registered.
  - active = 0: output permanently low.
  - active > TOP: output permanently high.
  - active = TOP: high for TOP of the TOP+1 ticks.
- period_start <= wrap, registered. It aligns with the first output cycle computed from count = 0.
- Reset values: pre=0, count=0, shadow=0, active=0, pending=0, pwm_out=8'h00, period_start=0.
- Reset mid-period: all state returns to reset values on the next edge. A frame captured but not yet committed is discarded. After reset is released, counting restarts from count=0.

## Timing
- pwm_out lags the count/active state by 1 cycle (registered compare).
- frame_done to active update:
  - Minimum 0 cycles when coincident with wrap.
  - Maximum (TOP+1)*PRESCALE - 1 cycles.
- Committed duties take effect on pwm_out starting at the cycle period_start is high.
- Period length: exactly (TOP+1)*PRESCALE clock cycles.
- period_start pulse spacing: the same (TOP+1)*PRESCALE cycles.
- A transition of pwm_out[i] occurs at most twice per period: rising at period start and falling when count reaches active[i].
- No combinational path from any input to any output.

## Test plan
- Reset, then 3 full periods with TOP=9, PRESCALE=1 -> pwm_out=0 throughout; period_start pulses every 10 cycles; pending=0.
- frame_done with v0=3, v1=0, v2=10, v7=9, all others 5, injected mid-period ->
  - pending=1 and pwm_out unchanged until the next period_start.
  - Then per 10-cycle period: ch0 high 3 cycles, ch1 always low, ch2 always high, ch7 high 9 cycles, others high 5 cycles.
- Two frame_done strobes in one period (v0=2, then v0=7) -> only 7 is committed at the next wrap.
- frame_done coincident with the wrap cycle, v0=4 -> active0=4 in the immediately following period; pending stays 0.
- PRESCALE=3, TOP=3, v0=2 -> period 12 cycles; ch0 high 6 cycles; period_start every 12 cycles.
- Reset asserted while pending=1 and active0=5 -> after release, pwm_out=0; the discarded frame is never committed; count restarts at 0.

Source files
------------

// File: rtl/pwm_bank_if.sv
// Reader-to-PWM link: eight duty words qualified by a one-cycle frame strobe, plus PWM status back.
// The reader side is the master; pwm_bank is the slave and drives the pin outputs.
interface pwm_bank_if;
   logic        frame_done;
   logic [15:0] v0;
   logic [15:0] v1;
   logic [15:0] v2;
   logic [15:0] v3;
   logic [15:0] v4;
   logic [15:0] v5;
   logic [15:0] v6;
   logic [15:0] v7;
   logic [7:0]  pwm_out;
   logic        period_start;
   logic        pending;

   modport master (
      output frame_done, v0, v1, v2, v3, v4, v5, v6, v7,
      input  pwm_out, period_start, pending
   );

   modport slave (
      input  frame_done, v0, v1, v2, v3, v4, v5, v6, v7,
      output pwm_out, period_start, pending
   );
endinterface

// File: rtl/pwm_bank.sv
// Eight-channel PWM with shadowed duty words committed only at period wrap; all outputs registered.
// No backpressure: a frame strobe is always accepted, and a newer frame overwrites an uncommitted one.
module pwm_bank #(
   parameter logic [15:0] TOP      = 16'hFFFF,
   parameter int          PRESCALE = 1
) (
   input logic       clock,
   input logic       reset,
   pwm_bank_if.slave bus
);

   localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_q,    pre_d;
   logic [15:0]   count_q,  count_d;
   logic [15:0]   shadow_q [8];
   logic [15:0]   shadow_d [8];
   logic [15:0]   active_q [8];
   logic [15:0]   active_d [8];
   logic          pending_q, pending_d;
   logic [7:0]    pwm_q,    pwm_d;
   logic          wrap_q,   wrap_d;
   logic          start_q,  start_d;

   logic [15:0]   v_in [8];
   logic          tick;
   logic          at_top;
   logic          wrap;

   assign v_in[0] = bus.v0;
   assign v_in[1] = bus.v1;
   assign v_in[2] = bus.v2;
   assign v_in[3] = bus.v3;
   assign v_in[4] = bus.v4;
   assign v_in[5] = bus.v5;
   assign v_in[6] = bus.v6;
   assign v_in[7] = bus.v7;

   always_comb begin
      tick   = (pre_q == PRE_LAST);
      at_top = (count_q == TOP);
      wrap   = tick && at_top;

      pre_d   = tick ? '0 : pre_q + 1'b1;
      count_d = count_q;
      if (tick) begin
         count_d = at_top ? 16'd0 : count_q + 16'd1;
      end
   end

   // A frame landing on the wrap cycle commits straight from the inputs.
   always_comb begin
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      if (wrap && bus.frame_done) begin
         shadow_d  = v_in;
         active_d  = v_in;
         pending_d = 1'b0;
      end else if (wrap && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end else if (bus.frame_done) begin
         shadow_d  = v_in;
         pending_d = 1'b1;
      end
   end

   // period_start is delayed one extra stage so it lines up with the first
   // registered compare result taken from count = 0.
   always_comb begin
      pwm_d = '0;
      for (int i = 0; i < 8; i++) begin
         pwm_d[i] = (count_q < active_q[i]);
      end
      wrap_d  = wrap;
      start_d = wrap_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pre_q     <= '0;
         count_q   <= '0;
         pending_q <= 1'b0;
         pwm_q     <= '0;
         wrap_q    <= 1'b0;
         start_q   <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         pre_q     <= pre_d;
         count_q   <= count_d;
         pending_q <= pending_d;
         pwm_q     <= pwm_d;
         wrap_q    <= wrap_d;
         start_q   <= start_d;
         for (int i = 0; i < 8; i++) begin
            shadow_q[i] <= shadow_d[i];
            active_q[i] <= active_d[i];
         end
      end
   end

   assign bus.pwm_out      = pwm_q;
   assign bus.period_start = start_q;
   assign bus.pending      = pending_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank: cycle scoreboard on a TOP=9/PRESCALE=1 instance plus directed
// period measurements on it and on a TOP=3/PRESCALE=3 instance.
module tb_pwm_bank;

   localparam int A_TOP = 9;
   localparam int A_PS  = 1;
   localparam int A_LEN = A_PS * (A_TOP + 1);

   logic clk;
   logic rst_a;
   logic rst_b;

   int n_checks;
   int n_errors;

   logic [15:0] fv [8];
   logic [9:0]  exp_q [$];

   pwm_bank_if bus_a ();
   pwm_bank_if bus_b ();

   pwm_bank #(.TOP(16'd9), .PRESCALE(1)) dut_a (
      .clock (clk),
      .reset (rst_a),
      .bus   (bus_a)
   );

   pwm_bank #(.TOP(16'd3), .PRESCALE(3)) dut_b (
      .clock (clk),
      .reset (rst_b),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference for instance A, written in terms of elapsed cycles since reset.
   int          m_t;
   logic [15:0] m_sh  [8];
   logic [15:0] m_act [8];
   logic        m_pend;
   logic        m_wrap1;

   always @(posedge clk) begin
      logic [7:0]  e_pwm;
      logic        e_ps;
      logic        w;
      int          cnt;
      logic [15:0] va [8];
      if (rst_a) begin
         m_t = 0; m_pend = 1'b0; m_wrap1 = 1'b0;
         for (int i = 0; i < 8; i++) begin m_sh[i] = '0; m_act[i] = '0; end
         exp_q.push_back(10'd0);
      end else begin
         va[0] = bus_a.v0; va[1] = bus_a.v1; va[2] = bus_a.v2; va[3] = bus_a.v3;
         va[4] = bus_a.v4; va[5] = bus_a.v5; va[6] = bus_a.v6; va[7] = bus_a.v7;
         cnt = (m_t / A_PS) % (A_TOP + 1);
         w   = ((m_t % A_LEN) == A_LEN - 1);
         for (int i = 0; i < 8; i++) e_pwm[i] = (cnt < int'(m_act[i]));
         e_ps = m_wrap1;
         if (w && bus_a.frame_done) begin
            for (int i = 0; i < 8; i++) begin m_sh[i] = va[i]; m_act[i] = va[i]; end
            m_pend = 1'b0;
         end else if (w && m_pend) begin
            for (int i = 0; i < 8; i++) m_act[i] = m_sh[i];
            m_pend = 1'b0;
         end else if (bus_a.frame_done) begin
            for (int i = 0; i < 8; i++) m_sh[i] = va[i];
            m_pend = 1'b1;
         end
         m_wrap1 = w;
         m_t++;
         exp_q.push_back({e_pwm, e_ps, m_pend});
      end
   end

   always @(negedge clk) begin
      logic [9:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("sb_pwm_out", {24'd0, bus_a.pwm_out}, {24'd0, e[9:2]});
         chk("sb_period_start", {31'd0, bus_a.period_start}, {31'd0, e[1]});
         chk("sb_pending", {31'd0, bus_a.pending}, {31'd0, e[0]});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input bit sel);
      if (!sel) begin
         bus_a.v0 = fv[0]; bus_a.v1 = fv[1]; bus_a.v2 = fv[2]; bus_a.v3 = fv[3];
         bus_a.v4 = fv[4]; bus_a.v5 = fv[5]; bus_a.v6 = fv[6]; bus_a.v7 = fv[7];
         bus_a.frame_done = 1'b1;
      end else begin
         bus_b.v0 = fv[0]; bus_b.v1 = fv[1]; bus_b.v2 = fv[2]; bus_b.v3 = fv[3];
         bus_b.v4 = fv[4]; bus_b.v5 = fv[5]; bus_b.v6 = fv[6]; bus_b.v7 = fv[7];
         bus_b.frame_done = 1'b1;
      end
      step();
      bus_a.frame_done = 1'b0;
      bus_b.frame_done = 1'b0;
   endtask

   function automatic logic ps(input bit sel);
      return sel ? bus_b.period_start : bus_a.period_start;
   endfunction

   // Waits for a period_start, then counts high cycles per channel up to the next one.
   task automatic meas(input bit sel, output int len, output int hi [8], output bit ok);
      int         n;
      logic [7:0] pw;
      ok = 1'b0; len = 0; n = 0;
      for (int i = 0; i < 8; i++) hi[i] = 0;
      while (ps(sel) !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (ps(sel) === 1'b1) begin
         do begin
            pw = sel ? bus_b.pwm_out : bus_a.pwm_out;
            for (int i = 0; i < 8; i++) hi[i] += int'(pw[i]);
            len++;
            @(negedge clk);
         end while (ps(sel) !== 1'b1 && len < 100);
         ok = (ps(sel) === 1'b1);
      end
   endtask

   task automatic check_period(input bit sel, input string tag, input int exp_len, input int exp_hi [8]);
      int len;
      int hi [8];
      bit ok;
      meas(sel, len, hi, ok);
      chk({tag, "_found"}, {31'd0, ok}, 32'd1);
      chk({tag, "_len"}, len, exp_len);
      for (int i = 0; i < 8; i++) chk($sformatf("%s_hi%0d", tag, i), hi[i], exp_hi[i]);
   endtask

   task automatic release_and_time(input string tag);
      int n;
      rst_a = 1'b0;
      @(negedge clk);
      n = 1;
      chk({tag, "_pwm"}, {24'd0, bus_a.pwm_out}, 32'd0);
      chk({tag, "_pending"}, {31'd0, bus_a.pending}, 32'd0);
      chk({tag, "_start"}, {31'd0, bus_a.period_start}, 32'd0);
      while (bus_a.period_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk({tag, "_first_start"}, n, A_LEN + 2);
   endtask

   initial begin
      int zero_hi [8];
      int exp_hi  [8];
      n_checks = 0;
      n_errors = 0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      for (int i = 0; i < 8; i++) begin fv[i] = '0; zero_hi[i] = 0; end
      bus_a.frame_done = 1'b0;
      bus_b.frame_done = 1'b0;
      frame(0); frame(1);
      repeat (3) step();

      release_and_time("rst");
      for (int p = 0; p < 3; p++) check_period(0, "idle", 10, zero_hi);

      repeat (3) step();
      for (int i = 0; i < 8; i++) fv[i] = 16'd5;
      fv[0] = 16'd3; fv[1] = 16'd0; fv[2] = 16'd10; fv[7] = 16'd9;
      frame(0);
      @(negedge clk);
      chk("mid_pending", {31'd0, bus_a.pending}, 32'd1);
      chk("mid_pwm_held", {24'd0, bus_a.pwm_out}, 32'd0);
      exp_hi[0] = 3; exp_hi[1] = 0; exp_hi[2] = 10; exp_hi[7] = 9;
      for (int i = 3; i < 7; i++) exp_hi[i] = 5;
      check_period(0, "duty", 10, exp_hi);

      repeat (2) step();
      fv[0] = 16'd2;
      frame(0);
      step();
      fv[0] = 16'd7;
      frame(0);
      @(negedge clk);
      chk("b2b_pending", {31'd0, bus_a.pending}, 32'd1);
      exp_hi[0] = 7;
      check_period(0, "b2b", 10, exp_hi);

      repeat (8) step();
      fv[0] = 16'd4;
      frame(0);
      @(negedge clk);
      chk("coinc_pending", {31'd0, bus_a.pending}, 32'd0);
      exp_hi[0] = 4;
      check_period(0, "coinc", 10, exp_hi);

      step();
      fv[0] = 16'd5;
      frame(0);
      exp_hi[0] = 5;
      check_period(0, "pre_rst", 10, exp_hi);
      repeat (2) step();
      fv[0] = 16'd8;
      frame(0);
      @(negedge clk);
      chk("rst_pending_before", {31'd0, bus_a.pending}, 32'd1);
      step();
      rst_a = 1'b1;
      repeat (2) step();
      release_and_time("mid_rst");
      check_period(0, "post_rst", 10, zero_hi);

      step();
      rst_b = 1'b0;
      for (int i = 0; i < 8; i++) fv[i] = '0;
      fv[0] = 16'd2;
      frame(1);
      exp_hi = zero_hi;
      exp_hi[0] = 6;
      check_period(1, "ps3_a", 12, exp_hi);
      check_period(1, "ps3_b", 12, exp_hi);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no completion, expected summary before 200000");
      $fatal(1, "timeout");
   end

endmodule
